hs_upload_reader: RTL and testbench
===================================

Name: hs_upload_reader

Overview:
- Serves HPS upload requests (the save direction of the hiscore/NVRAM interface) by reading bytes from game work RAM and presenting them on ioctl_din.
- A region table is loaded by a dedicated ioctl download. On upload the block requests a CPU pause, walks the concatenated regions, and stalls the HPS with ioctl_wait.
- Sits beside hps_io and the core's RAM read port in clk_sys.

Parameters:
- ADDR_W, 11, RAM address width.
- MAX_REG, 4, number of region table entries.
- CFG_INDEX, 3, ioctl_index that loads the region table.
- UP_INDEX, 4, ioctl_index served on upload.
- RAM_LAT, 1, RAM read latency in cycles (1..3).

Ports:
- clk_sys  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- ioctl_download  in  1  HPS download active
- ioctl_upload  in  1  HPS upload active
- ioctl_index  in  8  transfer index
- ioctl_wr  in  1  download byte strobe
- ioctl_rd  in  1  upload byte request strobe
- ioctl_addr  in  25  byte address
- ioctl_dout  in  8  download data
- ioctl_din  out  8  upload data
- ioctl_wait  out  1  stall HPS
- paused  in  1  CPU pause acknowledge
- pause_req  out  1  CPU pause request
- ram_addr  out  ADDR_W  RAM read address
- ram_rd  out  1  RAM read strobe
- ram_data  in  8  RAM read data
- configured  out  1  table valid

Behaviour:
- Reset (reset_n=0 at a clock edge): the following are all 0: ioctl_din, ioctl_wait, pause_req, ram_addr, ram_rd, configured. The table is cleared and the FSM goes to IDLE. This applies mid-operation as well.
- Table load: runs when ioctl_download && ioctl_index==CFG_INDEX && ioctl_wr.
  - Byte address a < 4*MAX_REG writes entry a/4, byte a%4, in order start_hi, start_lo, len_hi, len_lo.
  - Higher addresses are ignored. start is masked to ADDR_W bits.
  - On the falling edge of that download, the FSM enters CALC and computes 18-bit cumulative offsets cum_k and total = sum of len_k over MAX_REG cycles.
  - The first entry with len=0 terminates the table; it and all later entries contribute 0.
  - configured is set after CALC iff entry0 len != 0.
- FSM states: IDLE, CALC, REQ, WAIT_PAUSE, READY, MAP, RDWAIT, DONE.
- IDLE -> REQ when ioctl_upload && ioctl_index==UP_INDEX.
  - If configured=0: pause_req stays 0, ioctl_wait stays 0, and every ioctl_rd returns 0xFF one cycle later.
- REQ: pause_req=1, ioctl_wait=1, then go to WAIT_PAUSE. Leave WAIT_PAUSE for READY on the first cycle paused=1.
- READY:
  - ioctl_wait=0.
  - ioctl_rd at cycle t with address A goes to MAP at t+1, with ioctl_wait=1.
  - In MAP, find k with cum_k <= A < cum_k+len_k. Drive ram_addr = (start_k + A - cum_k) mod 2^ADDR_W and ram_rd=1 for exactly one cycle.
  - In RDWAIT, capture ram_data at t+1+RAM_LAT.
  - At t+2+RAM_LAT: ioctl_din updated, ioctl_wait=0, back to READY.
  - If A >= total: no ram_rd, ioctl_din=0xFF at t+2, ioctl_wait high only at t+1.
- ioctl_rd while not in READY is ignored.
- paused falling while in READY/MAP/RDWAIT: finish any in-flight byte, then go to WAIT_PAUSE with ioctl_wait=1.
- ioctl_upload falling in any state: go to DONE, abandon any in-flight read, and drop pause_req and ioctl_wait the next cycle. DONE -> IDLE.
- A table download during an upload is ignored until IDLE.
- ioctl_din holds its last value between requests.

Test Plan:
- Load table {0x0100,len 4},{0x07FE,len 3},{len 0}, then upload with paused tied high 2 cycles after pause_req.
  - Required: configured=1, total=7.
  - rd A=0..6 gives ram_addr 0x100,0x101,0x102,0x103,0x7FE,0x7FF,0x000 (wrap).
  - ioctl_din equals the RAM model contents.
- Latency: RAM_LAT=2, rd at cycle 10.
  - Required: ram_rd at 11 only, ioctl_wait high 11..13, ioctl_din valid and wait low at 14.
- Out-of-range: rd A=7 with total=7.
  - Required: no ram_rd, ioctl_din=0xFF at t+2.
- Unconfigured upload: rd A=0.
  - Required: pause_req=0, ioctl_din=0xFF.
- Pause handshake: paused held low 20 cycles.
  - Required: ioctl_wait=1 throughout and rd ignored. paused rising gives ioctl_wait=0 next cycle.
- Abort/reset: drop ioctl_upload mid-RDWAIT.
  - Required: pause_req=0 and ioctl_wait=0 within 1 cycle.
  - Separately, reset_n=0 mid-upload clears all outputs and configured on the next edge.

Source files
------------

// File: rtl/hs_upload_reader.sv
`default_nettype none
// ----------------------------------------------------------------------------
// hs_upload_reader: answers HPS upload reads from work RAM via a region table
// Rev 1.0
// ----------------------------------------------------------------------------
module hs_upload_reader #(
  parameter int ADDR_W    = 11,
  parameter int MAX_REG   = 4,
  parameter int CFG_INDEX = 3,
  parameter int UP_INDEX  = 4,
  parameter int RAM_LAT   = 1
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              ioctl_download,
  input  logic              ioctl_upload,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_wr,
  input  logic              ioctl_rd,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  output logic [7:0]        ioctl_din,
  output logic              ioctl_wait,
  input  logic              paused,
  output logic              pause_req,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_rd,
  input  logic [7:0]        ram_data,
  output logic              configured
);

  localparam int IDX_W = (MAX_REG > 1) ? $clog2(MAX_REG) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_CALC, S_REQ, S_WAIT_PAUSE, S_READY, S_MAP, S_RDWAIT, S_DONE
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] start_q [MAX_REG];
  logic [15:0]       len_q   [MAX_REG];
  logic [17:0]       cum_q   [MAX_REG];
  logic [17:0]       total_q;
  logic [17:0]       acc_q;
  logic              term_q;
  logic [IDX_W-1:0]  calc_idx_q;
  logic              cfg_dl_q;
  logic              miss_q;
  logic              pause_lost_q;
  logic [1:0]        lat_cnt_q;
  logic [7:0]        din_q;
  logic              wait_q;
  logic              pause_req_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic              ram_rd_q;
  logic              configured_q;

  logic              w_cfg_dl;
  logic              w_cfg_fall;
  logic              w_cfg_wr;
  logic              w_up_sel;
  logic [IDX_W-1:0]  w_wr_idx;
  logic [15:0]       w_calc_len;
  logic              w_hit;
  logic [ADDR_W-1:0] w_map_addr;
  logic [17:0]       w_off;
  logic              w_lost;
  logic              w_active;

  always_comb begin
    w_cfg_dl   = ioctl_download && (ioctl_index == 8'(CFG_INDEX));
    w_cfg_fall = cfg_dl_q && !w_cfg_dl;
    w_cfg_wr   = w_cfg_dl && ioctl_wr && (ioctl_addr < 25'(4 * MAX_REG));
    w_up_sel   = ioctl_upload && (ioctl_index == 8'(UP_INDEX));
    w_wr_idx   = ioctl_addr[IDX_W+1:2];
    w_calc_len = (term_q || (len_q[calc_idx_q] == 16'd0)) ? 16'd0 : len_q[calc_idx_q];
    w_lost     = pause_lost_q || !paused;
    w_active   = (state_q == S_REQ) || (state_q == S_WAIT_PAUSE) || (state_q == S_READY) ||
                 (state_q == S_MAP) || (state_q == S_RDWAIT);
  end

  // Region lookup straight from the request address so ram_rd can be registered for MAP.
  always_comb begin
    w_hit      = 1'b0;
    w_map_addr = '0;
    w_off      = '0;
    for (int k = 0; k < MAX_REG; k++) begin
      w_off = ioctl_addr[17:0] - cum_q[k];
      if (!w_hit && (ioctl_addr < 25'(total_q)) && (ioctl_addr[17:0] >= cum_q[k]) &&
          (w_off < 18'(len_q[k]))) begin
        w_hit      = 1'b1;
        w_map_addr = start_q[k] + w_off[ADDR_W-1:0];
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      for (int i = 0; i < MAX_REG; i++) begin
        start_q[i] <= '0;
        len_q[i]   <= '0;
        cum_q[i]   <= '0;
      end
      total_q      <= '0;
      acc_q        <= '0;
      term_q       <= 1'b0;
      calc_idx_q   <= '0;
      cfg_dl_q     <= 1'b0;
      miss_q       <= 1'b0;
      pause_lost_q <= 1'b0;
      lat_cnt_q    <= '0;
      din_q        <= '0;
      wait_q       <= 1'b0;
      pause_req_q  <= 1'b0;
      ram_addr_q   <= '0;
      ram_rd_q     <= 1'b0;
      configured_q <= 1'b0;
    end else begin
      cfg_dl_q <= w_cfg_dl;
      ram_rd_q <= 1'b0;
      if (w_active && !ioctl_upload) begin
        state_q     <= S_DONE;
        pause_req_q <= 1'b0;
        wait_q      <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (w_cfg_wr) begin
              case (ioctl_addr[1:0])
                2'd0: start_q[w_wr_idx] <= (ADDR_W'(ioctl_dout) << 8) |
                                           (start_q[w_wr_idx] & ADDR_W'(8'hFF));
                2'd1: start_q[w_wr_idx] <= (start_q[w_wr_idx] & ~ADDR_W'(8'hFF)) |
                                           ADDR_W'(ioctl_dout);
                2'd2: len_q[w_wr_idx]   <= {ioctl_dout, len_q[w_wr_idx][7:0]};
                default: len_q[w_wr_idx] <= {len_q[w_wr_idx][15:8], ioctl_dout};
              endcase
            end
            if (w_cfg_fall) begin
              state_q      <= S_CALC;
              calc_idx_q   <= '0;
              acc_q        <= '0;
              term_q       <= 1'b0;
              configured_q <= 1'b0;
            end else if (w_up_sel && configured_q) begin
              state_q     <= S_REQ;
              pause_req_q <= 1'b1;
              wait_q      <= 1'b1;
            end else if (w_up_sel && ioctl_rd) begin
              din_q <= 8'hFF;
            end
          end
          // Entries from the first zero length onward are zeroed so lookups never hit them.
          S_CALC: begin
            cum_q[calc_idx_q] <= acc_q;
            len_q[calc_idx_q] <= w_calc_len;
            acc_q             <= acc_q + 18'(w_calc_len);
            if (w_calc_len == 16'd0) term_q <= 1'b1;
            if (calc_idx_q == IDX_W'(MAX_REG - 1)) begin
              total_q      <= acc_q + 18'(w_calc_len);
              configured_q <= (len_q[0] != 16'd0);
              state_q      <= S_IDLE;
            end else begin
              calc_idx_q <= calc_idx_q + IDX_W'(1);
            end
          end
          S_REQ: state_q <= S_WAIT_PAUSE;
          S_WAIT_PAUSE: begin
            if (paused) begin
              state_q <= S_READY;
              wait_q  <= 1'b0;
            end
          end
          S_READY: begin
            if (!paused) begin
              state_q <= S_WAIT_PAUSE;
              wait_q  <= 1'b1;
            end else if (ioctl_rd) begin
              state_q      <= S_MAP;
              wait_q       <= 1'b1;
              pause_lost_q <= 1'b0;
              miss_q       <= !w_hit;
              if (w_hit) begin
                ram_rd_q   <= 1'b1;
                ram_addr_q <= w_map_addr;
              end
            end
          end
          S_MAP: begin
            if (miss_q) begin
              din_q   <= 8'hFF;
              state_q <= w_lost ? S_WAIT_PAUSE : S_READY;
              wait_q  <= w_lost;
            end else begin
              lat_cnt_q    <= 2'(RAM_LAT - 1);
              pause_lost_q <= w_lost;
              state_q      <= S_RDWAIT;
            end
          end
          S_RDWAIT: begin
            if (lat_cnt_q == 2'd0) begin
              din_q   <= ram_data;
              state_q <= w_lost ? S_WAIT_PAUSE : S_READY;
              wait_q  <= w_lost;
            end else begin
              lat_cnt_q    <= lat_cnt_q - 2'd1;
              pause_lost_q <= w_lost;
            end
          end
          default: begin
            pause_req_q <= 1'b0;
            wait_q      <= 1'b0;
            state_q     <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign ioctl_din  = din_q;
  assign ioctl_wait = wait_q;
  assign pause_req  = pause_req_q;
  assign ram_addr   = ram_addr_q;
  assign ram_rd     = ram_rd_q;
  assign configured = configured_q;

endmodule
`default_nettype wire

// File: tb/tb_hs_upload_reader.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_hs_upload_reader: directed bench for hs_upload_reader with a 2-cycle RAM
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_hs_upload_reader;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        ioctl_download = 1'b0;
  logic        ioctl_upload = 1'b0;
  logic [7:0]  ioctl_index = 8'd0;
  logic        ioctl_wr = 1'b0;
  logic        ioctl_rd = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = 8'd0;
  logic [7:0]  ioctl_din;
  logic        ioctl_wait;
  logic        paused = 1'b0;
  logic        pause_req;
  logic [10:0] ram_addr;
  logic        ram_rd;
  logic [7:0]  ram_data;
  logic        configured;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_sys = ~clk_sys;

  hs_upload_reader #(
    .ADDR_W(11), .MAX_REG(4), .CFG_INDEX(3), .UP_INDEX(4), .RAM_LAT(2)
  ) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_download(ioctl_download),
    .ioctl_upload(ioctl_upload), .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr),
    .ioctl_rd(ioctl_rd), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .ioctl_din(ioctl_din), .ioctl_wait(ioctl_wait), .paused(paused),
    .pause_req(pause_req), .ram_addr(ram_addr), .ram_rd(ram_rd),
    .ram_data(ram_data), .configured(configured)
  );

  function automatic logic [7:0] memval(input logic [10:0] a);
    logic [15:0] x;
    x = {5'b0, a} * 16'd37 + 16'd11;
    return x[7:0] ^ {5'b0, a[10:8]};
  endfunction

  // Two-stage read pipeline: data valid two cycles after the address cycle.
  logic [7:0] p1 = 8'd0, p2 = 8'd0;
  always @(posedge clk_sys) begin
    p1 <= memval(ram_addr);
    p2 <= p1;
  end
  assign ram_data = p2;

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick(); tick();
    n_cmp++; if (ioctl_din !== 8'h00) begin n_err++; $display("FAIL reset_din got %h want 00", ioctl_din); end
    n_cmp++; if (ioctl_wait !== 1'b0) begin n_err++; $display("FAIL reset_wait got %b want 0", ioctl_wait); end
    n_cmp++; if (pause_req !== 1'b0) begin n_err++; $display("FAIL reset_pause_req got %b want 0", pause_req); end
    n_cmp++; if (ram_addr !== 11'h000) begin n_err++; $display("FAIL reset_ram_addr got %h want 000", ram_addr); end
    n_cmp++; if (ram_rd !== 1'b0) begin n_err++; $display("FAIL reset_ram_rd got %b want 0", ram_rd); end
    n_cmp++; if (configured !== 1'b0) begin n_err++; $display("FAIL reset_configured got %b want 0", configured); end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_unconfigured();
    ioctl_upload = 1'b1; ioctl_index = 8'd4; paused = 1'b1;
    tick();
    ioctl_addr = 25'd0; ioctl_rd = 1'b1;
    tick();
    ioctl_rd = 1'b0;
    n_cmp++; if (pause_req !== 1'b0) begin n_err++; $display("FAIL uncfg_pause_req got %b want 0", pause_req); end
    n_cmp++; if (ioctl_wait !== 1'b0) begin n_err++; $display("FAIL uncfg_wait got %b want 0", ioctl_wait); end
    n_cmp++; if (ioctl_din !== 8'hFF) begin n_err++; $display("FAIL uncfg_din got %h want FF", ioctl_din); end
    ioctl_upload = 1'b0; paused = 1'b0;
    tick(); tick();
  endtask

  task automatic test_table_load();
    logic [7:0] bytes [17];
    bytes = '{8'h01, 8'h00, 8'h00, 8'h04,  8'h07, 8'hFE, 8'h00, 8'h03,
              8'h00, 8'h00, 8'h00, 8'h00,  8'h00, 8'h10, 8'h00, 8'h05, 8'h55};
    ioctl_download = 1'b1; ioctl_index = 8'd3;
    tick();
    for (int i = 0; i < 17; i++) begin
      ioctl_addr = (i == 16) ? 25'd20 : 25'(i);
      ioctl_dout = bytes[i];
      ioctl_wr   = 1'b1;
      tick();
      ioctl_wr   = 1'b0;
      tick();
    end
    ioctl_download = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    n_cmp++; if (configured !== 1'b1) begin n_err++; $display("FAIL cfg_configured got %b want 1", configured); end
  endtask

  task automatic test_pause_handshake();
    ioctl_upload = 1'b1; ioctl_index = 8'd4; paused = 1'b0; ioctl_addr = 25'd0;
    tick();
    n_cmp++; if (pause_req !== 1'b1) begin n_err++; $display("FAIL hs_pause_req got %b want 1", pause_req); end
    for (int i = 0; i < 20; i++) begin
      ioctl_rd = (i % 3) != 0;
      tick();
      n_cmp++; if (ioctl_wait !== 1'b1) begin n_err++; $display("FAIL hs_wait cyc %0d got %b want 1", i, ioctl_wait); end
      n_cmp++; if (ram_rd !== 1'b0) begin n_err++; $display("FAIL hs_rd_ignored cyc %0d got %b want 0", i, ram_rd); end
    end
    ioctl_rd = 1'b0;
    paused = 1'b1;
    tick();
    n_cmp++; if (ioctl_wait !== 1'b0) begin n_err++; $display("FAIL hs_wait_release got %b want 0", ioctl_wait); end
  endtask

  task automatic test_latency();
    ioctl_addr = 25'd0; ioctl_rd = 1'b1;
    tick();
    ioctl_rd = 1'b0;
    n_cmp++; if (ram_rd !== 1'b1) begin n_err++; $display("FAIL lat_rd_t1 got %b want 1", ram_rd); end
    n_cmp++; if (ioctl_wait !== 1'b1) begin n_err++; $display("FAIL lat_wait_t1 got %b want 1", ioctl_wait); end
    tick();
    n_cmp++; if (ram_rd !== 1'b0) begin n_err++; $display("FAIL lat_rd_t2 got %b want 0", ram_rd); end
    n_cmp++; if (ioctl_wait !== 1'b1) begin n_err++; $display("FAIL lat_wait_t2 got %b want 1", ioctl_wait); end
    tick();
    n_cmp++; if (ioctl_wait !== 1'b1) begin n_err++; $display("FAIL lat_wait_t3 got %b want 1", ioctl_wait); end
    tick();
    n_cmp++; if (ioctl_wait !== 1'b0) begin n_err++; $display("FAIL lat_wait_t4 got %b want 0", ioctl_wait); end
    n_cmp++; if (ioctl_din !== memval(11'h100)) begin n_err++; $display("FAIL lat_din got %h want %h", ioctl_din, memval(11'h100)); end
  endtask

  task automatic test_map_walk();
    logic [10:0] exp_addr [7];
    exp_addr = '{11'h100, 11'h101, 11'h102, 11'h103, 11'h7FE, 11'h7FF, 11'h000};
    for (int a = 0; a < 7; a++) begin
      ioctl_addr = 25'(a); ioctl_rd = 1'b1;
      tick();
      ioctl_rd = 1'b0;
      n_cmp++; if (ram_rd !== 1'b1 || ram_addr !== exp_addr[a]) begin
        n_err++; $display("FAIL walk_addr A=%0d got rd=%b addr=%h want rd=1 addr=%h", a, ram_rd, ram_addr, exp_addr[a]);
      end
      tick(); tick(); tick();
      n_cmp++; if (ioctl_din !== memval(exp_addr[a]) || ioctl_wait !== 1'b0) begin
        n_err++; $display("FAIL walk_din A=%0d got %h wait=%b want %h wait=0", a, ioctl_din, ioctl_wait, memval(exp_addr[a]));
      end
    end
    tick(); tick(); tick();
    n_cmp++; if (ioctl_din !== memval(11'h000)) begin n_err++; $display("FAIL din_hold got %h want %h", ioctl_din, memval(11'h000)); end
  endtask

  task automatic test_out_of_range();
    logic [24:0] addrs [2];
    addrs = '{25'd7, 25'h0040000};
    for (int i = 0; i < 2; i++) begin
      ioctl_addr = addrs[i]; ioctl_rd = 1'b1;
      tick();
      ioctl_rd = 1'b0;
      n_cmp++; if (ram_rd !== 1'b0 || ioctl_wait !== 1'b1) begin
        n_err++; $display("FAIL oor_t1 A=%h got rd=%b wait=%b want rd=0 wait=1", addrs[i], ram_rd, ioctl_wait);
      end
      tick();
      n_cmp++; if (ioctl_din !== 8'hFF || ioctl_wait !== 1'b0) begin
        n_err++; $display("FAIL oor_t2 A=%h got din=%h wait=%b want din=FF wait=0", addrs[i], ioctl_din, ioctl_wait);
      end
      tick();
    end
  endtask

  task automatic test_pause_drop();
    ioctl_addr = 25'd1; ioctl_rd = 1'b1;
    tick();
    ioctl_rd = 1'b0; paused = 1'b0;
    tick(); tick(); tick();
    n_cmp++; if (ioctl_din !== memval(11'h101)) begin n_err++; $display("FAIL pdrop_din got %h want %h", ioctl_din, memval(11'h101)); end
    n_cmp++; if (ioctl_wait !== 1'b1) begin n_err++; $display("FAIL pdrop_wait got %b want 1", ioctl_wait); end
    tick();
    n_cmp++; if (ioctl_wait !== 1'b1) begin n_err++; $display("FAIL pdrop_wait_hold got %b want 1", ioctl_wait); end
    paused = 1'b1;
    tick();
    n_cmp++; if (ioctl_wait !== 1'b0) begin n_err++; $display("FAIL pdrop_resume got %b want 0", ioctl_wait); end
  endtask

  task automatic test_abort();
    ioctl_addr = 25'd2; ioctl_rd = 1'b1;
    tick();
    ioctl_rd = 1'b0;
    tick();
    ioctl_upload = 1'b0;
    tick();
    n_cmp++; if (pause_req !== 1'b0) begin n_err++; $display("FAIL abort_pause_req got %b want 0", pause_req); end
    n_cmp++; if (ioctl_wait !== 1'b0) begin n_err++; $display("FAIL abort_wait got %b want 0", ioctl_wait); end
    tick(); tick();
    n_cmp++; if (ioctl_din !== memval(11'h101)) begin n_err++; $display("FAIL abort_din got %h want %h", ioctl_din, memval(11'h101)); end
  endtask

  task automatic test_reset_mid();
    ioctl_upload = 1'b1; ioctl_index = 8'd4; paused = 1'b1;
    tick(); tick(); tick();
    ioctl_addr = 25'd3; ioctl_rd = 1'b1;
    tick();
    ioctl_rd = 1'b0;
    reset_n = 1'b0;
    tick();
    n_cmp++; if (ioctl_din !== 8'h00 || ioctl_wait !== 1'b0 || pause_req !== 1'b0) begin
      n_err++; $display("FAIL rmid_a got din=%h wait=%b preq=%b want 00 0 0", ioctl_din, ioctl_wait, pause_req);
    end
    n_cmp++; if (ram_addr !== 11'h000 || ram_rd !== 1'b0 || configured !== 1'b0) begin
      n_err++; $display("FAIL rmid_b got addr=%h rd=%b cfg=%b want 000 0 0", ram_addr, ram_rd, configured);
    end
    reset_n = 1'b1; ioctl_upload = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_unconfigured();
    test_table_load();
    test_pause_handshake();
    test_latency();
    test_map_walk();
    test_out_of_range();
    test_pause_drop();
    test_abort();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
